// File: rtl/run_ctrl.sv
// Core reset/run sequencer: synchronised reset release, staggered per-channel
// core reset release, RUN cycle counting, halt and optional timeout (RUN_CTRL_TIMEOUT_EN).
module run_ctrl #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned HOLD    = 4,
  parameter int unsigned STAGGER = 2,
  parameter int unsigned CNT_W   = 32,
  parameter logic [63:0] TIMEOUT = 64'd100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt_req,
  input  logic             soft_rst_req,
  output logic [NCH-1:0]   core_rst_n,
  output logic             running,
  output logic             halted,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Hold count on which the last channel is released.
  localparam int unsigned LAST = HOLD + (NCH - 1) * STAGGER;
  localparam int unsigned HC_W = $clog2(LAST + 1) + 1;

  state_t             state_q, state_d;
  logic               rst_meta;
  logic [HC_W-1:0]    hold_q, hold_d;
  logic [NCH-1:0]     core_q, core_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               halted_q, halted_d;
  logic               to_q, to_d;
  logic               running_q;

`ifdef RUN_CTRL_TIMEOUT_EN
  logic timeout_hit;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 64'd1));
`else
  logic timeout_hit;
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // First synchroniser stage; the state register is the second stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_meta <= 1'b0;
    else        rst_meta <= 1'b1;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RST;
      hold_q    <= '0;
      core_q    <= '0;
      cnt_q     <= '0;
      halted_q  <= 1'b0;
      to_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      core_q    <= core_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      to_q      <= to_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    core_d   = core_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    to_d     = to_q;

    case (state_q)
      ST_RST: begin
        hold_d   = '0;
        core_d   = '0;
        cnt_d    = '0;
        halted_d = 1'b0;
        to_d     = 1'b0;
        if (rst_meta) state_d = ST_HOLD;
      end

      ST_HOLD: begin
        if (soft_rst_req) begin
          hold_d = '0;
          core_d = '0;
        end else begin
          hold_d = hold_q + HC_W'(1);
          for (int i = 0; i < int'(NCH); i++) begin
            if (hold_q == HC_W'(HOLD + i * STAGGER - 1)) core_d[i] = 1'b1;
          end
          if (hold_q == HC_W'(LAST - 1)) state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (soft_rst_req) begin
          state_d = ST_HOLD;
          hold_d  = '0;
          core_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          if (halt_req) begin
            state_d  = ST_DONE;
            halted_d = 1'b1;
          end else if (timeout_hit) begin
            state_d = ST_DONE;
            to_d    = 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (soft_rst_req) begin
          state_d  = ST_HOLD;
          hold_d   = '0;
          core_d   = '0;
          cnt_d    = '0;
          halted_d = 1'b0;
          to_d     = 1'b0;
        end
      end

      default: state_d = ST_RST;
    endcase
  end

  assign state      = state_q;
  assign core_rst_n = core_q;
  assign cycle_cnt  = cnt_q;
  assign halted     = halted_q;
  assign timed_out  = to_q;
  assign running    = running_q;

endmodule
